// File: rtl/alarm_bank_ctrl_pkg.sv
// Shared encodings for the alarm bank: channel states, RTC time layout and a
// helper that tells whether a stored HHMMSS value is a real time of day.
package alarm_bank_ctrl_pkg;

  localparam int TIME_W  = 18;
  localparam int FIELD_W = 6;
  localparam int HH_MSB  = 17;
  localparam int MM_MSB  = 11;
  localparam int SS_MSB  = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  // Out-of-range stored times are kept but must never fire.
  function automatic logic time_is_valid(input logic [TIME_W-1:0] t);
    return (t[HH_MSB -: FIELD_W] <= 6'd23) &&
           (t[MM_MSB -: FIELD_W] <= 6'd59) &&
           (t[SS_MSB -: FIELD_W] <= 6'd59);
  endfunction

endpackage

// File: rtl/alarm_bank_ctrl_if.sv
// Bus between the RTC / UI side (master) and the alarm bank (slave).
interface alarm_bank_ctrl_if
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) ();

  logic                  sec_tick;
  logic [TIME_W-1:0]     rtc_data;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [TIME_W-1:0]     wr_time;
  logic                  wr_enable;
  logic                  snooze;
  logic                  dismiss;
  logic                  alarm_active;
  logic [IDX_W-1:0]      active_idx;
  logic [NUM_ALARMS-1:0] ringing;
  logic [NUM_ALARMS-1:0] snoozed;
  logic [NUM_ALARMS-1:0] missed;
  logic [NUM_ALARMS-1:0] en_status;
  logic                  buzzer_req;

  modport master (
    output sec_tick, rtc_data, wr_en, wr_idx, wr_time, wr_enable, snooze, dismiss,
    input  alarm_active, active_idx, ringing, snoozed, missed, en_status, buzzer_req
  );

  modport slave (
    input  sec_tick, rtc_data, wr_en, wr_idx, wr_time, wr_enable, snooze, dismiss,
    output alarm_active, active_idx, ringing, snoozed, missed, en_status, buzzer_req
  );

endinterface

// File: rtl/alarm_bank_ctrl_channel.sv
// One alarm channel: stored time, enable, IDLE/RINGING/SNOOZED machine, a
// shared ring/snooze second counter and the sticky missed flag. Write, snooze
// and dismiss strobes arrive already qualified for this channel.
module alarm_channel
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_tick_i,
  input  logic [TIME_W-1:0] rtc_data_i,
  input  logic              wr_en_i,
  input  logic [TIME_W-1:0] wr_time_i,
  input  logic              wr_enable_i,
  input  logic              snooze_i,
  input  logic              dismiss_i,
  output logic              ringing_o,
  output logic              snoozed_o,
  output logic              missed_o,
  output logic              en_o
);

  localparam int MAX_SEC = (SNOOZE_SEC > RING_TIMEOUT_SEC) ? SNOOZE_SEC : RING_TIMEOUT_SEC;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic              en_q, en_d;
  logic              missed_q, missed_d;
  logic              match;

  assign match = sec_tick_i && en_q && (time_q == rtc_data_i) && time_is_valid(time_q);

  // Next-state: write beats dismiss beats snooze beats timeout/expiry beats match.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    time_d   = time_q;
    en_d     = en_q;
    missed_d = missed_q;
    if (wr_en_i) begin
      time_d   = wr_time_i;
      en_d     = wr_enable_i;
      missed_d = 1'b0;
      if (!wr_enable_i) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end
        end
        ST_RINGING: begin
          if (dismiss_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (snooze_i) begin
            state_d = ST_SNOOZED;
            cnt_d   = CNT_W'(SNOOZE_SEC);
          end else if (sec_tick_i) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(RING_TIMEOUT_SEC)) begin
              state_d  = ST_IDLE;
              cnt_d    = '0;
              missed_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_SNOOZED: begin
          if (sec_tick_i) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_RINGING;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Channel state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      // NOTE: the stored alarm time is ordinary flops, so it resets with everything else.
      time_q   <= '0;
      en_q     <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      en_q     <= en_d;
      missed_q <= missed_d;
    end
  end

  assign ringing_o = (state_q == ST_RINGING);
  assign snoozed_o = (state_q == ST_SNOOZED);
  assign missed_o  = missed_q;
  assign en_o      = en_q;

endmodule

// File: rtl/alarm_bank_ctrl.sv
// Alarm bank top: NUM_ALARMS channels, lowest-index arbitration to one
// active channel, snooze/dismiss steered to that channel, registered buzzer.
module alarm_bank_ctrl
  import alarm_bank_ctrl_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int IDX_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input logic               CLK,
  input logic               RESETN,
  alarm_bank_ctrl_if.slave  bus_if
);

  logic [NUM_ALARMS-1:0] ringing, snoozed, missed, en_status;
  logic [NUM_ALARMS-1:0] wr_sel, snooze_sel, dismiss_sel;
  logic                  alarm_active;
  logic [IDX_W-1:0]      active_idx;
  logic                  buzzer_q;

  // Lowest-index RINGING channel wins; scan high to low so the last hit is the lowest.
  always_comb begin
    active_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ringing[i]) active_idx = IDX_W'(i);
    end
  end

  assign alarm_active = |ringing;

  // Steer writes by WR_IDX and snooze/dismiss only to the active channel.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      wr_sel[i]      = bus_if.wr_en && (bus_if.wr_idx == IDX_W'(i));
      snooze_sel[i]  = bus_if.snooze && alarm_active && (active_idx == IDX_W'(i));
      dismiss_sel[i] = bus_if.dismiss && alarm_active && (active_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .SNOOZE_SEC       (SNOOZE_SEC),
      .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
    ) u_ch (
      .clk         (CLK),
      .rst_n       (RESETN),
      .sec_tick_i  (bus_if.sec_tick),
      .rtc_data_i  (bus_if.rtc_data),
      .wr_en_i     (wr_sel[g]),
      .wr_time_i   (bus_if.wr_time),
      .wr_enable_i (bus_if.wr_enable),
      .snooze_i    (snooze_sel[g]),
      .dismiss_i   (dismiss_sel[g]),
      .ringing_o   (ringing[g]),
      .snoozed_o   (snoozed[g]),
      .missed_o    (missed[g]),
      .en_o        (en_status[g])
    );
  end

  // Buzzer request trails ALARM_ACTIVE by one cycle.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) buzzer_q <= 1'b0;
    else         buzzer_q <= alarm_active;
  end

  assign bus_if.alarm_active = alarm_active;
  assign bus_if.active_idx   = active_idx;
  assign bus_if.ringing      = ringing;
  assign bus_if.snoozed      = snoozed;
  assign bus_if.missed       = missed;
  assign bus_if.en_status    = en_status;
  assign bus_if.buzzer_req   = buzzer_q;

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// Directed bench for alarm_bank_ctrl with 4 channels, 3 s snooze, 5 s ring timeout.
module tb_alarm_bank_ctrl;
  import alarm_bank_ctrl_pkg::*;

  logic CLK;
  logic RESETN;
  int   n_checks = 0;
  int   n_pass   = 0;

  alarm_bank_ctrl_if #(.NUM_ALARMS(4), .IDX_W(2)) bus ();

  alarm_bank_ctrl #(
    .NUM_ALARMS       (4),
    .SNOOZE_SEC       (3),
    .RING_TIMEOUT_SEC (5),
    .IDX_W            (2)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus_if (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic logic [17:0] tm(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick(input logic [17:0] t);
    bus.rtc_data = t;
    bus.sec_tick = 1'b1;
    cycle();
    bus.sec_tick = 1'b0;
  endtask

  task automatic write_ch(input logic [1:0] idx, input logic [17:0] t, input logic en);
    bus.wr_en     = 1'b1;
    bus.wr_idx    = idx;
    bus.wr_time   = t;
    bus.wr_enable = en;
    cycle();
    bus.wr_en     = 1'b0;
  endtask

  task automatic pulse(input logic sn, input logic di);
    bus.snooze  = sn;
    bus.dismiss = di;
    cycle();
    bus.snooze  = 1'b0;
    bus.dismiss = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ringing"}, 32'(bus.ringing), 32'h0);
    check({tag, " snoozed"}, 32'(bus.snoozed), 32'h0);
    check({tag, " missed"},  32'(bus.missed),  32'h0);
    check({tag, " en"},      32'(bus.en_status), 32'h0);
    check({tag, " active"},  32'(bus.alarm_active), 32'h0);
    check({tag, " idx"},     32'(bus.active_idx), 32'h0);
    check({tag, " buzzer"},  32'(bus.buzzer_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0;
    bus.sec_tick = 1'b0; bus.rtc_data = '0; bus.wr_en = 1'b0; bus.wr_idx = '0;
    bus.wr_time = '0; bus.wr_enable = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
    cycle(); cycle();
    check_all_zero("reset");
    RESETN = 1'b1;
    cycle();

    // Single alarm on ch2.
    write_ch(2'd2, tm(7, 30, 0), 1'b1);
    check("en ch2", 32'(bus.en_status), 32'h4);
    tick(tm(7, 29, 59));
    check("no early ring", 32'(bus.ringing), 32'h0);
    tick(tm(7, 30, 0));
    check("ch2 ringing", 32'(bus.ringing), 32'h4);
    check("ch2 idx", 32'(bus.active_idx), 32'd2);
    check("ch2 active", 32'(bus.alarm_active), 32'h1);
    check("buzzer lag", 32'(bus.buzzer_req), 32'h0);
    cycle();
    check("buzzer on", 32'(bus.buzzer_req), 32'h1);
    pulse(1'b0, 1'b1);
    check("ch2 dismissed", 32'(bus.ringing), 32'h0);
    cycle();
    check("buzzer off", 32'(bus.buzzer_req), 32'h0);

    // Two channels on the same tick, dismissed in priority order.
    write_ch(2'd0, tm(6, 0, 0), 1'b1);
    write_ch(2'd3, tm(6, 0, 0), 1'b1);
    tick(tm(6, 0, 0));
    check("dual ringing", 32'(bus.ringing), 32'h9);
    check("dual idx", 32'(bus.active_idx), 32'd0);
    pulse(1'b0, 1'b1);
    check("after dismiss0", 32'(bus.ringing), 32'h8);
    check("idx moves to 3", 32'(bus.active_idx), 32'd3);
    pulse(1'b0, 1'b1);
    check("all dismissed", 32'(bus.ringing), 32'h0);
    check("inactive", 32'(bus.alarm_active), 32'h0);
    pulse(1'b1, 1'b0);
    check("idle snooze ignored", 32'(bus.snoozed), 32'h0);

    // Snooze on ch1: re-rings on the third tick.
    write_ch(2'd1, tm(8, 0, 0), 1'b1);
    tick(tm(8, 0, 0));
    check("ch1 ringing", 32'(bus.ringing), 32'h2);
    pulse(1'b1, 1'b0);
    check("ch1 snoozed", 32'(bus.snoozed), 32'h2);
    check("ch1 not ringing", 32'(bus.ringing), 32'h0);
    tick(tm(8, 0, 1));
    tick(tm(8, 0, 2));
    check("snooze 2 ticks", 32'(bus.ringing), 32'h0);
    tick(tm(8, 0, 3));
    check("snooze expiry ring", 32'(bus.ringing), 32'h2);
    check("snooze cleared", 32'(bus.snoozed), 32'h0);
    pulse(1'b0, 1'b1);

    // Ring timeout on ch1 after 5 unattended ticks.
    tick(tm(8, 0, 0));
    for (int i = 1; i <= 4; i++) tick(tm(9, 0, i));
    check("ring 4 ticks", 32'(bus.ringing), 32'h2);
    check("not missed yet", 32'(bus.missed), 32'h0);
    tick(tm(9, 0, 5));
    check("timed out", 32'(bus.ringing), 32'h0);
    check("missed set", 32'(bus.missed), 32'h2);
    write_ch(2'd1, tm(8, 0, 0), 1'b1);
    check("missed cleared", 32'(bus.missed), 32'h0);

    // Snooze+dismiss together: dismiss wins.
    tick(tm(6, 0, 0));
    check("dual again", 32'(bus.ringing), 32'h9);
    pulse(1'b1, 1'b1);
    check("dismiss wins ring", 32'(bus.ringing), 32'h8);
    check("dismiss wins snz", 32'(bus.snoozed), 32'h0);
    pulse(1'b0, 1'b1);

    // Disabling write on a snoozed channel forces it idle.
    tick(tm(6, 0, 0));
    pulse(1'b1, 1'b0);
    check("ch0 snoozed", 32'(bus.snoozed), 32'h1);
    check("ch3 active", 32'(bus.active_idx), 32'd3);
    pulse(1'b0, 1'b1);
    write_ch(2'd0, tm(6, 0, 0), 1'b0);
    check("ch0 forced idle", 32'(bus.snoozed), 32'h0);
    check("ch0 disabled", 32'(bus.en_status), 32'he);
    for (int i = 0; i < 4; i++) tick(tm(10, 0, i));
    check("ch0 stays idle", 32'(bus.ringing), 32'h0);

    // Asynchronous reset mid-snooze and mid-ring.
    tick(tm(6, 0, 0));
    pulse(1'b1, 1'b0);
    tick(tm(8, 0, 0));
    check("pre-reset ring", 32'(bus.ringing), 32'h2);
    check("pre-reset snz", 32'(bus.snoozed), 32'h8);
    #2;
    RESETN = 1'b0;
    #1;
    check_all_zero("async reset");
    cycle();
    RESETN = 1'b1;
    tick(tm(6, 0, 0));
    tick(tm(8, 0, 0));
    check("no ring after reset", 32'(bus.ringing), 32'h0);

    // Write on a matching tick suppresses that tick's match only.
    bus.wr_en = 1'b1; bus.wr_idx = 2'd2; bus.wr_time = tm(7, 30, 0); bus.wr_enable = 1'b1;
    bus.rtc_data = tm(7, 30, 0); bus.sec_tick = 1'b1;
    cycle();
    bus.wr_en = 1'b0; bus.sec_tick = 1'b0;
    check("write suppresses match", 32'(bus.ringing), 32'h0);
    check("write stored en", 32'(bus.en_status), 32'h4);
    tick(tm(7, 30, 0));
    check("next tick matches", 32'(bus.ringing), 32'h4);
    pulse(1'b0, 1'b1);

    // Out-of-range stored time never fires.
    write_ch(2'd2, tm(24, 0, 0), 1'b1);
    tick(tm(24, 0, 0));
    check("invalid time no ring", 32'(bus.ringing), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
